// File: rtl/sw_host_loader_if.sv
// Host-side push bus of sw_host_loader: the T word stream and the S chunk stream,
// each with its own valid/ready handshake.
interface sw_host_loader_if #(
    parameter int PE_NUM = 16,
    parameter int PE_LOG = 4
);
    logic [17:0]         i_t_wdata;
    logic                i_t_wvalid;
    logic                o_t_wready;
    logic [2*PE_NUM-1:0] i_s_wdata;
    logic [PE_LOG:0]     i_s_wcount;
    logic                i_s_wlast;
    logic                i_s_wvalid;
    logic                o_s_wready;

    modport master (
        output i_t_wdata, i_t_wvalid, i_s_wdata, i_s_wcount, i_s_wlast, i_s_wvalid,
        input  o_t_wready, o_s_wready
    );
    modport slave (
        input  i_t_wdata, i_t_wvalid, i_s_wdata, i_s_wcount, i_s_wlast, i_s_wvalid,
        output o_t_wready, o_s_wready
    );
endinterface

// File: rtl/sw_host_loader.sv
// Buffers host T words and S chunks, then sequences them into the alignment core.
// Optional SW_LOADER_TIMEOUT_EN adds a 50000-cycle watchdog on the two wait states.
module sw_host_loader #(
    parameter int PE_NUM  = 16,
    parameter int PE_LOG  = 4,
    parameter int RES_W   = 16,
    parameter int T_DEPTH = 16,
    parameter int S_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    sw_host_loader_if.slave     host,
    input  logic [23:0]         i_param,
    input  logic                i_go,
    output logic                o_set_t,
    output logic [17:0]         o_t,
    output logic                o_start_cal,
    output logic                o_param_valid,
    output logic [23:0]         o_param,
    input  logic                i_busy,
    input  logic                i_request_s,
    output logic [2*PE_NUM-1:0] o_s,
    output logic [PE_LOG:0]     o_s_valid,
    input  logic                i_valid,
    input  logic [RES_W-1:0]    i_result,
    output logic [RES_W-1:0]    o_result,
    output logic                o_result_valid,
    output logic                o_idle,
    output logic                o_err,
    output logic                o_timeout
);
    localparam int TA = $clog2(T_DEPTH);
    localparam int SA = $clog2(S_DEPTH);
    localparam int SW = 2*PE_NUM + PE_LOG + 2;

    typedef enum logic [2:0] {IDLE, SEND_T, WAIT_BUSY, START, STREAM_S, WAIT_RES} state_t;
    state_t state_q, state_d;

    logic [17:0]   t_mem [T_DEPTH];
    logic [TA-1:0] t_wp_q, t_rp_q;
    logic [TA:0]   t_cnt_q, term_cnt_q;
    logic          t_push, t_pop, t_head_term, t_in_term;
    logic [17:0]   t_head;

    logic [SW-1:0] s_mem [S_DEPTH];
    logic [SA-1:0] s_wp_q, s_rp_q;
    logic [SA:0]   s_cnt_q;
    logic          s_push, s_pop, s_bypass, s_empty;
    logic [SW-1:0] sel_word;

    logic [17:0]         o_t_q;
    logic                set_t_q, first_q, pend_q, pend_d, serve, err_set, err_q;
    logic [23:0]         param_q;
    logic [2*PE_NUM-1:0] o_s_q;
    logic [PE_LOG:0]     o_s_valid_q;
    logic [RES_W-1:0]    result_q;
    logic                result_valid_q, tmo_hit;

    assign host.o_t_wready = (t_cnt_q != (TA+1)'(T_DEPTH));
    assign host.o_s_wready = (s_cnt_q != (SA+1)'(S_DEPTH));
    assign t_push      = host.i_t_wvalid && host.o_t_wready;
    assign t_head      = t_mem[t_rp_q];
    assign t_head_term = |t_head[16:14];
    assign t_in_term   = |host.i_t_wdata[16:14];
    // A chunk handed straight to a pending request never enters the FIFO.
    assign s_push   = host.i_s_wvalid && host.o_s_wready && !s_bypass;
    assign s_empty  = (s_cnt_q == '0);
    assign sel_word = s_empty ? {host.i_s_wdata, host.i_s_wcount, host.i_s_wlast} : s_mem[s_rp_q];

    always_ff @(posedge clk) begin
        if (t_push) t_mem[t_wp_q] <= host.i_t_wdata;
        if (s_push) s_mem[s_wp_q] <= {host.i_s_wdata, host.i_s_wcount, host.i_s_wlast};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_wp_q <= '0; t_rp_q <= '0; t_cnt_q <= '0; term_cnt_q <= '0;
            s_wp_q <= '0; s_rp_q <= '0; s_cnt_q <= '0;
        end else begin
            if (t_push) t_wp_q <= t_wp_q + TA'(1);
            if (t_pop)  t_rp_q <= t_rp_q + TA'(1);
            t_cnt_q    <= t_cnt_q + (TA+1)'(t_push) - (TA+1)'(t_pop);
            term_cnt_q <= term_cnt_q + (TA+1)'(t_push && t_in_term) - (TA+1)'(t_pop && t_head_term);
            if (s_push) s_wp_q <= s_wp_q + SA'(1);
            if (s_pop)  s_rp_q <= s_rp_q + SA'(1);
            s_cnt_q <= s_cnt_q + (SA+1)'(s_push) - (SA+1)'(s_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        t_pop    = 1'b0;
        s_pop    = 1'b0;
        s_bypass = 1'b0;
        serve    = 1'b0;
        pend_d   = pend_q;
        err_set  = 1'b0;
        case (state_q)
            IDLE:      if (i_go && term_cnt_q != '0) state_d = SEND_T;
            SEND_T: begin
                t_pop = 1'b1;
                if (t_head_term) state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (!i_busy) state_d = START;
            START:     state_d = STREAM_S;
            STREAM_S: begin
                if (i_request_s || pend_q) begin
                    if (!s_empty) begin
                        serve = 1'b1;
                        s_pop = 1'b1;
                    end else if (host.i_s_wvalid) begin
                        serve    = 1'b1;
                        s_bypass = 1'b1;
                    end
                    if (serve) begin
                        pend_d = pend_q && i_request_s;
                        if (sel_word[0]) state_d = WAIT_RES;
                    end else begin
                        pend_d  = 1'b1;
                        err_set = pend_q && i_request_s;
                    end
                end
            end
            WAIT_RES:  if (i_valid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (i_request_s && state_q != STREAM_S) err_set = 1'b1;
        if (i_valid && state_q != WAIT_RES)     err_set = 1'b1;
        if (tmo_hit)                             state_d = IDLE;
        if (state_d != STREAM_S)                 pend_d  = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_t_q <= '0; set_t_q <= 1'b0; first_q <= 1'b0; pend_q <= 1'b0;
            param_q <= '0; o_s_q <= '0; o_s_valid_q <= '0;
            result_q <= '0; result_valid_q <= 1'b0; err_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            first_q <= (state_q == IDLE);
            o_t_q   <= t_pop ? t_head : 18'd0;
            set_t_q <= t_pop && first_q;
            if (state_q == IDLE && state_d == SEND_T) param_q <= i_param;
            o_s_q       <= serve ? sel_word[SW-1 -: 2*PE_NUM] : '0;
            o_s_valid_q <= serve ? sel_word[PE_LOG+1:1] : '0;
            if (state_q == WAIT_RES && i_valid) result_q <= i_result;
            result_valid_q <= (state_q == WAIT_RES) && i_valid;
            err_q <= err_q || err_set;
        end
    end

`ifdef SW_LOADER_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        tmo_q;
    assign tmo_hit = (tmo_cnt_q == 16'd50000);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if ((state_q == WAIT_BUSY || state_q == WAIT_RES) && !tmo_hit) tmo_cnt_q <= tmo_cnt_q + 16'd1;
            else                                                            tmo_cnt_q <= '0;
            if (tmo_hit) tmo_q <= 1'b1;
        end
    end
    assign o_timeout = tmo_q;
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_t            = o_t_q;
    assign o_set_t        = set_t_q;
    assign o_start_cal    = (state_q == START);
    assign o_param_valid  = (state_q == START);
    assign o_param        = (state_q == START) ? param_q : 24'd0;
    assign o_s            = o_s_q;
    assign o_s_valid      = o_s_valid_q;
    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;
    assign o_idle         = (state_q == IDLE);
    assign o_err          = err_q;
endmodule

// File: tb/tb_sw_host_loader.sv
// Self-checking bench for sw_host_loader: directed scenarios plus randomized runs
// checked against a queue-based model of the host/core transfer sequence.
module tb_sw_host_loader;
    localparam int PE_NUM = 16;
    localparam int PE_LOG = 4;
    localparam int RES_W  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sw_host_loader_if #(.PE_NUM(PE_NUM), .PE_LOG(PE_LOG)) host ();

    logic [23:0]         i_param;
    logic                i_go, i_busy, i_request_s, i_valid;
    logic [RES_W-1:0]    i_result;
    logic                o_set_t, o_start_cal, o_param_valid;
    logic [17:0]         o_t;
    logic [23:0]         o_param;
    logic [2*PE_NUM-1:0] o_s;
    logic [PE_LOG:0]     o_s_valid;
    logic [RES_W-1:0]    o_result;
    logic                o_result_valid, o_idle, o_err, o_timeout;

    int errors = 0;
    int checks = 0;

    sw_host_loader #(.PE_NUM(PE_NUM), .PE_LOG(PE_LOG), .RES_W(RES_W), .T_DEPTH(16), .S_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .host(host),
        .i_param(i_param), .i_go(i_go),
        .o_set_t(o_set_t), .o_t(o_t),
        .o_start_cal(o_start_cal), .o_param_valid(o_param_valid), .o_param(o_param),
        .i_busy(i_busy), .i_request_s(i_request_s),
        .o_s(o_s), .o_s_valid(o_s_valid),
        .i_valid(i_valid), .i_result(i_result),
        .o_result(o_result), .o_result_valid(o_result_valid), .o_idle(o_idle),
        .o_err(o_err), .o_timeout(o_timeout)
    );

    task automatic push_t(input logic [17:0] w);
        host.i_t_wdata  = w;
        host.i_t_wvalid = 1'b1;
        checks++;
        if (host.o_t_wready !== 1'b1) begin errors++; $display("FAIL t_wready: got %0b want 1", host.o_t_wready); end
        @(negedge clk);
        host.i_t_wvalid = 1'b0;
    endtask

    task automatic push_s(input logic [31:0] d, input logic [4:0] c, input logic l);
        host.i_s_wdata  = d;
        host.i_s_wcount = c;
        host.i_s_wlast  = l;
        host.i_s_wvalid = 1'b1;
        checks++;
        if (host.o_s_wready !== 1'b1) begin errors++; $display("FAIL s_wready: got %0b want 1", host.o_s_wready); end
        @(negedge clk);
        host.i_s_wvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        i_param = '0; i_go = 0; i_busy = 0; i_request_s = 0; i_valid = 0; i_result = '0;
        host.i_t_wdata = '0; host.i_t_wvalid = 0;
        host.i_s_wdata = '0; host.i_s_wcount = '0; host.i_s_wlast = 0; host.i_s_wvalid = 0;
        do_reset();
        checks++;
        if (o_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b want 1", o_idle); end
        checks++;
        if ({host.o_t_wready, host.o_s_wready} !== 2'b11) begin errors++; $display("FAIL reset_wready: got %b want 11", {host.o_t_wready, host.o_s_wready}); end
        checks++;
        if ({o_set_t, o_start_cal, o_param_valid, o_result_valid, o_err, o_timeout} !== 6'd0) begin
            errors++; $display("FAIL reset_strobes: got %b want 000000", {o_set_t, o_start_cal, o_param_valid, o_result_valid, o_err, o_timeout});
        end
        checks++;
        if ({o_t, o_param, o_s, o_s_valid, o_result} !== '0) begin
            errors++; $display("FAIL reset_data: got t=%h p=%h s=%h sv=%0d r=%h want all 0", o_t, o_param, o_s, o_s_valid, o_result);
        end
    endtask

    task automatic test_send_t();
        logic [17:0] exp_t [4];
        logic        exp_set [4];
        logic        exp_start [4];
        logic [23:0] par;
        exp_t[0] = 18'h00001; exp_t[1] = 18'h00002; exp_t[2] = 18'h04003; exp_t[3] = 18'h0;
        exp_set[0] = 1; exp_set[1] = 0; exp_set[2] = 0; exp_set[3] = 0;
        exp_start[0] = 0; exp_start[1] = 0; exp_start[2] = 0; exp_start[3] = 1;
        push_t(18'h00001); push_t(18'h00002); push_t(18'h04003);
        par = 24'($urandom);
        i_param = par; i_busy = 0; i_go = 1;
        @(negedge clk);
        i_go = 0; i_param = ~par;
        checks++;
        if ({o_idle, o_t} !== 19'd0) begin errors++; $display("FAIL sendt_first: got idle=%0b t=%h want 0 0", o_idle, o_t); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (o_t !== exp_t[i] || o_set_t !== exp_set[i] || o_start_cal !== exp_start[i]) begin
                errors++;
                $display("FAIL sendt_cycle%0d: got t=%h set=%0b start=%0b want t=%h set=%0b start=%0b",
                         i, o_t, o_set_t, o_start_cal, exp_t[i], exp_set[i], exp_start[i]);
            end
        end
        checks++;
        if (o_param !== par || o_param_valid !== 1'b1) begin errors++; $display("FAIL start_param: got %h/%0b want %h/1", o_param, o_param_valid, par); end
        @(negedge clk);
        checks++;
        if ({o_start_cal, o_param_valid, o_param} !== 26'd0) begin errors++; $display("FAIL start_one_cycle: got %0b %0b %h want 0 0 0", o_start_cal, o_param_valid, o_param); end
    endtask

    task automatic test_pending();
        logic [31:0] d;
        d = $urandom;
        i_request_s = 1;
        @(negedge clk);
        i_request_s = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_s_valid !== '0) begin errors++; $display("FAIL pend_wait%0d: got sv=%0d want 0", k, o_s_valid); end
            if (k < 3) @(negedge clk);
        end
        push_s(d, 5'd7, 1'b0);
        checks++;
        if (o_s_valid !== 5'd7 || o_s !== d) begin errors++; $display("FAIL pend_serve: got sv=%0d s=%h want 7 %h", o_s_valid, o_s, d); end
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL pend_err: got %0b want 0", o_err); end
        @(negedge clk);
        checks++;
        if (o_s_valid !== '0) begin errors++; $display("FAIL pend_one_cycle: got sv=%0d want 0", o_s_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] d [3];
        logic [4:0]  c [3];
        c[0] = 16; c[1] = 16; c[2] = 5;
        for (int j = 0; j < 3; j++) begin
            d[j] = $urandom;
            push_s(d[j], c[j], j == 2);
        end
        for (int j = 0; j < 3; j++) begin
            i_request_s = 1;
            @(negedge clk);
            i_request_s = 0;
            checks++;
            if (o_s_valid !== c[j] || o_s !== d[j]) begin errors++; $display("FAIL stream_chunk%0d: got sv=%0d s=%h want %0d %h", j, o_s_valid, o_s, c[j], d[j]); end
            @(negedge clk);
            checks++;
            if (o_s_valid !== '0) begin errors++; $display("FAIL stream_gap%0d: got sv=%0d want 0", j, o_s_valid); end
        end
        checks++;
        if (o_idle !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL stream_state: got idle=%0b err=%0b want 0 0", o_idle, o_err); end
    endtask

    task automatic test_result();
        i_result = 16'h002A; i_valid = 1;
        @(negedge clk);
        i_valid = 0; i_result = 16'hFFFF;
        checks++;
        if (o_result !== 16'h002A || o_result_valid !== 1'b1 || o_idle !== 1'b1) begin
            errors++; $display("FAIL result: got r=%h rv=%0b idle=%0b want 002a 1 1", o_result, o_result_valid, o_idle);
        end
        @(negedge clk);
        checks++;
        if (o_result_valid !== 1'b0 || o_result !== 16'h002A) begin errors++; $display("FAIL result_pulse: got rv=%0b r=%h want 0 002a", o_result_valid, o_result); end
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL result_err: got %0b want 0", o_err); end
    endtask

    task automatic test_errors();
        i_valid = 1;
        @(negedge clk);
        i_valid = 0;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1 || o_idle !== 1'b1) begin errors++; $display("FAIL err_valid_idle: got err=%0b idle=%0b want 1 1", o_err, o_idle); end
        do_reset();
        i_go = 1;
        @(negedge clk);
        i_go = 0;
        @(negedge clk);
        checks++;
        if (o_idle !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL go_ignored: got idle=%0b err=%0b want 1 0", o_idle, o_err); end
        push_t(18'h1C000);
        i_busy = 0; i_go = 1;
        @(negedge clk);
        i_go = 0;
        repeat (3) @(negedge clk);
        i_request_s = 1;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL err_first_req: got %0b want 0", o_err); end
        @(negedge clk);
        i_request_s = 0;
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL err_double_req: got %0b want 1", o_err); end
        do_reset();
    endtask

    task automatic test_random(input int runs);
        logic [17:0] tq [$];
        logic [31:0] sd [$];
        logic [4:0]  sc [$];
        logic [23:0] par;
        logic [15:0] res;
        int ntw, nsc, b;
        for (int r = 0; r < runs; r++) begin
            tq.delete(); sd.delete(); sc.delete();
            ntw = $urandom_range(0, 6);
            for (int i = 0; i < ntw; i++) tq.push_back({$urandom_range(0, 3) == 0 ? 1'b1 : 1'b0, 3'b000, 14'($urandom)});
            tq.push_back({1'($urandom), 3'($urandom_range(1, 7)), 14'($urandom)});
            nsc = $urandom_range(1, 6);
            for (int j = 0; j < nsc; j++) begin
                sd.push_back($urandom);
                sc.push_back(5'($urandom_range(1, 16)));
            end
            foreach (tq[i]) push_t(tq[i]);
            foreach (sd[j]) push_s(sd[j], sc[j], j == nsc - 1);
            par = 24'($urandom);
            b = $urandom_range(0, 3);
            i_busy = 1; i_param = par; i_go = 1;
            @(negedge clk);
            i_go = 0; i_param = 24'($urandom);
            foreach (tq[i]) begin
                @(negedge clk);
                checks++;
                if (o_t !== tq[i] || o_set_t !== (i == 0) || o_start_cal !== 1'b0) begin
                    errors++; $display("FAIL rnd%0d_t%0d: got t=%h set=%0b start=%0b want t=%h set=%0b start=0", r, i, o_t, o_set_t, o_start_cal, tq[i], i == 0);
                end
            end
            for (int k = 0; k < b; k++) begin
                @(negedge clk);
                checks++;
                if (o_start_cal !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy%0d: got start=%0b want 0", r, k, o_start_cal); end
            end
            i_busy = 0;
            @(negedge clk);
            checks++;
            if (o_start_cal !== 1'b1 || o_param !== par) begin errors++; $display("FAIL rnd%0d_start: got start=%0b p=%h want 1 %h", r, o_start_cal, o_param, par); end
            @(negedge clk);
            foreach (sd[j]) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    checks++;
                    if (o_s_valid !== '0) begin errors++; $display("FAIL rnd%0d_idle_s: got sv=%0d want 0", r, o_s_valid); end
                end
                i_request_s = 1;
                @(negedge clk);
                i_request_s = 0;
                checks++;
                if (o_s_valid !== sc[j] || o_s !== sd[j]) begin errors++; $display("FAIL rnd%0d_s%0d: got sv=%0d s=%h want %0d %h", r, j, o_s_valid, o_s, sc[j], sd[j]); end
            end
            res = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            i_result = res; i_valid = 1;
            @(negedge clk);
            i_valid = 0;
            checks++;
            if (o_result !== res || o_result_valid !== 1'b1 || o_idle !== 1'b1 || o_err !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_res: got r=%h rv=%0b idle=%0b err=%0b want %h 1 1 0", r, o_result, o_result_valid, o_idle, o_err, res);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_midrun_reset();
        logic [31:0] d;
        d = $urandom;
        push_t(18'h00123); push_t(18'h08456);
        push_s($urandom, 5'd16, 1'b0); push_s($urandom, 5'd9, 1'b1);
        i_busy = 0; i_param = 24'hABCDEF; i_go = 1;
        @(negedge clk);
        i_go = 0;
        repeat (4) @(negedge clk);
        i_request_s = 1;
        @(negedge clk);
        i_request_s = 0;
        checks++;
        if (o_s_valid !== 5'd16) begin errors++; $display("FAIL mid_pre: got sv=%0d want 16", o_s_valid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_set_t, o_t, o_start_cal, o_param_valid, o_param, o_s, o_s_valid, o_result, o_result_valid, o_err, o_timeout} !== '0) begin
            errors++; $display("FAIL mid_rst_out: got s=%h sv=%0d t=%h r=%h want all 0", o_s, o_s_valid, o_t, o_result);
        end
        checks++;
        if ({o_idle, host.o_t_wready, host.o_s_wready} !== 3'b111) begin errors++; $display("FAIL mid_rst_idle: got %b want 111", {o_idle, host.o_t_wready, host.o_s_wready}); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({o_set_t, o_start_cal, o_s_valid, o_result_valid, o_idle} !== 9'd1) begin
                errors++; $display("FAIL mid_quiet%0d: got set=%0b start=%0b sv=%0d rv=%0b idle=%0b want 0 0 0 0 1", k, o_set_t, o_start_cal, o_s_valid, o_result_valid, o_idle);
            end
        end
        i_go = 1;
        @(negedge clk);
        i_go = 0;
        @(negedge clk);
        checks++;
        if (o_idle !== 1'b1) begin errors++; $display("FAIL mid_t_empty: got idle=%0b want 1", o_idle); end
        push_t(18'h0C000);
        i_go = 1;
        @(negedge clk);
        i_go = 0;
        repeat (3) @(negedge clk);
        i_request_s = 1;
        @(negedge clk);
        i_request_s = 0;
        checks++;
        if (o_s_valid !== '0) begin errors++; $display("FAIL mid_s_empty: got sv=%0d want 0", o_s_valid); end
        push_s(d, 5'd3, 1'b1);
        checks++;
        if (o_s_valid !== 5'd3 || o_s !== d) begin errors++; $display("FAIL mid_s_after: got sv=%0d s=%h want 3 %h", o_s_valid, o_s, d); end
        i_result = 16'h1234; i_valid = 1;
        @(negedge clk);
        i_valid = 0;
        checks++;
        if (o_idle !== 1'b1 || o_result !== 16'h1234 || o_err !== 1'b0) begin errors++; $display("FAIL mid_finish: got idle=%0b r=%h err=%0b want 1 1234 0", o_idle, o_result, o_err); end
    endtask

`ifdef SW_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        push_t(18'h04000);
        i_busy = 1; i_go = 1;
        @(negedge clk);
        i_go = 0;
        @(negedge clk);
        n = 0;
        while (o_idle !== 1'b1 && n < 50100) begin
            @(negedge clk);
            n++;
            if (n == 100) begin
                checks++;
                if (o_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got %0b want 0", o_timeout); end
            end
        end
        checks++;
        if (o_idle !== 1'b1 || o_timeout !== 1'b1 || n < 49990 || n > 50010) begin
            errors++; $display("FAIL tmo: got idle=%0b tmo=%0b after %0d cycles want 1 1 ~50001", o_idle, o_timeout, n);
        end
        i_busy = 0;
        do_reset();
    endtask
`else
    task automatic test_timeout();
        push_t(18'h04000);
        i_busy = 1; i_go = 1;
        @(negedge clk);
        i_go = 0;
        repeat (200) @(negedge clk);
        checks++;
        if (o_timeout !== 1'b0 || o_idle !== 1'b0) begin errors++; $display("FAIL no_tmo: got tmo=%0b idle=%0b want 0 0", o_timeout, o_idle); end
        i_busy = 0;
        do_reset();
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_send_t();
        test_pending();
        test_stream();
        test_result();
        test_errors();
        test_random(20);
        test_midrun_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
